// File: rtl/uart_rx_assembler_pkg.sv
// Shared constants and helpers for the UART receive-side message assembler.
package uart_rx_assembler_pkg;

  localparam int unsigned F_CLK_HZ       = 32'd50_000_000;
  localparam int unsigned RX_GAP_TIMEOUT = F_CLK_HZ / 32'd1000;

  // Word count for a byte count, rounding up; 9-bit sum keeps LEN=255 exact.
  function automatic logic [7:0] words_from_len(input logic [7:0] len);
    logic [8:0] sum;
    sum = {1'b0, len} + 9'd1;
    return sum[8:1];
  endfunction

  function automatic logic [15:0] pack_word(input logic [7:0] msb, input logic [7:0] lsb);
    return {msb, lsb};
  endfunction

endpackage

// File: rtl/uart_rx_assembler_word_fifo.sv
// Show-ahead 16-bit word FIFO with synchronous flush; full/empty come from
// read/write pointers carrying one extra wrap bit.
module uart_rx_assembler_word_fifo #(
  parameter int DEPTH = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        WRREQ,
  input  logic        RDREQ,
  input  logic [15:0] D,
  output logic [15:0] Q,
  output logic        FULL,
  output logic        EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [15:0]  mem_r [DEPTH];
  logic         do_wr_s;
  logic         do_rd_s;

  assign EMPTY   = (wr_ptr_r == rd_ptr_r);
  assign FULL    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_wr_s = WRREQ && !FULL;
  assign do_rd_s = RDREQ && !EMPTY;
  assign Q       = EMPTY ? 16'h0000 : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; flush takes priority over any simultaneous push or pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (FLUSH) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge CLK) begin
    if (do_wr_s && !FLUSH) begin
      mem_r[wr_ptr_r[AW-1:0]] <= D;
    end
  end

endmodule

// File: rtl/uart_rx_assembler.sv
// Parses length-prefixed UART frames, packs payload bytes MSB-first into
// 16-bit words and holds the completed message until the consumer acks it.
module uart_rx_assembler
  import uart_rx_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH  = 128,
  parameter int GAP_TIMEOUT = RX_GAP_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  input  logic        RDREQ,
  output logic [15:0] FIFO_Q,
  output logic        FIFO_EMPTY,
  output logic        GOT_FULL_MESSAGE,
  input  logic        MSG_ACK,
  output logic [7:0]  MSG_LEN,
  output logic        PARITY_OUT,
  output logic        ERR_TIMEOUT,
  output logic        ERR_OVERFLOW,
  output logic [1:0]  state_mon
);

  localparam int TMR_W = $clog2(GAP_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] GAP_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] GAP_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LEN = 2'd0,
    ST_GET_MSB  = 2'd1,
    ST_GET_LSB  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [7:0]       bytes_left_r, bytes_left_nxt_s;
  logic [7:0]       msb_r, msb_nxt_s;
  logic [7:0]       msg_len_r, msg_len_nxt_s;
  logic             parity_r, parity_nxt_s;
  logic [TMR_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic             err_timeout_r, err_timeout_nxt_s;
  logic             err_overflow_r, err_overflow_nxt_s;
  logic             accept_s, gap_expired_s;
  logic             wr_attempt_s, wrreq_s, flush_s;
  logic             fifo_full_s;
  logic [15:0]      wr_word_s;

  assign RX_READY         = (state_r != ST_DONE);
  assign accept_s         = RX_VALID && RX_READY;
  assign gap_expired_s    = (gap_cnt_r == GAP_LAST);
  assign GOT_FULL_MESSAGE = (state_r == ST_DONE);
  assign state_mon        = state_r;
  assign MSG_LEN          = msg_len_r;
  assign PARITY_OUT       = parity_r;
  assign ERR_TIMEOUT      = err_timeout_r;
  assign ERR_OVERFLOW     = err_overflow_r;

  uart_rx_assembler_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .FLUSH (flush_s),
    .WRREQ (wrreq_s),
    .RDREQ (RDREQ),
    .D     (wr_word_s),
    .Q     (FIFO_Q),
    .FULL  (fifo_full_s),
    .EMPTY (FIFO_EMPTY)
  );

  // Next-state, word assembly, gap timer and error decisions.
  always_comb begin
    state_nxt_s        = state_r;
    bytes_left_nxt_s   = bytes_left_r;
    msb_nxt_s          = msb_r;
    msg_len_nxt_s      = msg_len_r;
    parity_nxt_s       = parity_r;
    gap_cnt_nxt_s      = GAP_ZERO;
    err_timeout_nxt_s  = 1'b0;
    err_overflow_nxt_s = 1'b0;
    wr_attempt_s       = 1'b0;
    wr_word_s          = 16'h0000;
    wrreq_s            = 1'b0;
    flush_s            = 1'b0;
    case (state_r)
      ST_WAIT_LEN: begin
        if (accept_s && (RX_DATA != 8'h00)) begin
          bytes_left_nxt_s = RX_DATA;
          msg_len_nxt_s    = words_from_len(RX_DATA);
          parity_nxt_s     = RX_DATA[0];
          state_nxt_s      = ST_GET_MSB;
        end else begin
          state_nxt_s = ST_WAIT_LEN;
        end
      end
      ST_GET_MSB: begin
        if (accept_s) begin
          msb_nxt_s        = RX_DATA;
          bytes_left_nxt_s = bytes_left_r - 8'd1;
          if (bytes_left_r == 8'd1) begin
            wr_attempt_s = 1'b1;
            wr_word_s    = pack_word(RX_DATA, 8'h00);
            state_nxt_s  = ST_DONE;
          end else begin
            state_nxt_s = ST_GET_LSB;
          end
        end else if (gap_expired_s) begin
          err_timeout_nxt_s = 1'b1;
          flush_s           = 1'b1;
          state_nxt_s       = ST_WAIT_LEN;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_ONE;
        end
      end
      ST_GET_LSB: begin
        if (accept_s) begin
          bytes_left_nxt_s = bytes_left_r - 8'd1;
          wr_attempt_s     = 1'b1;
          wr_word_s        = pack_word(msb_r, RX_DATA);
          if (bytes_left_r == 8'd1) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_GET_MSB;
          end
        end else if (gap_expired_s) begin
          err_timeout_nxt_s = 1'b1;
          flush_s           = 1'b1;
          state_nxt_s       = ST_WAIT_LEN;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_ONE;
        end
      end
      ST_DONE: begin
        if (MSG_ACK) begin
          flush_s     = 1'b1;
          state_nxt_s = ST_WAIT_LEN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_LEN;
      end
    endcase
    // A word arriving at a full FIFO aborts the whole frame.
    if (wr_attempt_s && fifo_full_s) begin
      err_overflow_nxt_s = 1'b1;
      flush_s            = 1'b1;
      state_nxt_s        = ST_WAIT_LEN;
    end else begin
      wrreq_s = wr_attempt_s;
    end
  end

  // Control and status registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r        <= ST_WAIT_LEN;
      bytes_left_r   <= 8'h00;
      msb_r          <= 8'h00;
      msg_len_r      <= 8'h00;
      parity_r       <= 1'b0;
      gap_cnt_r      <= GAP_ZERO;
      err_timeout_r  <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      bytes_left_r   <= bytes_left_nxt_s;
      msb_r          <= msb_nxt_s;
      msg_len_r      <= msg_len_nxt_s;
      parity_r       <= parity_nxt_s;
      gap_cnt_r      <= gap_cnt_nxt_s;
      err_timeout_r  <= err_timeout_nxt_s;
      err_overflow_r <= err_overflow_nxt_s;
    end
  end

endmodule
